wb_stage: RTL and testbench

- Writeback stage of the rv32i pipeline. Sits between the memory stage and the register file.
- Registers the MEM/WB payload and performs load byte/halfword extraction with sign or zero extension.
- Drives the regfile write port (waddr/wdata/wen).
- Backpressures the memory stage via a valid/ready handshake and maintains a retired-instruction counter.

---
 rtl/wb_stage.sv | 195 +++++++++++++++++++
 tb/tb_wb_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage : writeback stage of the rv32i pipeline.
//
// Registers the MEM/WB payload for one cycle, extracts and extends load bytes
// and halfwords, and drives the register file write port. A valid/ready
// handshake backpressures the memory stage; an optional 64-bit counter tracks
// retired instructions.
//
// Optional feature macro: WB_INSTRET_EN
//   defined   : 64-bit retired-instruction counter is built
//   undefined : no counter flops, instret is tied to zero
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_valid         memory stage presents an instruction
//   mem_ready         this stage accepts this cycle (= ~wb_stall)
//   mem_rd_addr       destination register
//   mem_rd_wen        instruction writes rd
//   mem_alu_result    ALU result / load effective address
//   mem_load_en       instruction is a load
//   mem_funct3        load width/sign code
//   mem_load_data     raw aligned word from data memory
//   wb_stall          backpressure from hazard unit
//   wb_flush          kill incoming instruction
//   waddr/wdata/wen   register file write port
//   wb_valid          an instruction retires this cycle
//   load_err          reserved load funct3 seen this cycle
//   instret           retired-instruction count
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [RADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                   mem_rd_wen,
    input  logic [DATA_WIDTH-1:0]  mem_alu_result,
    input  logic                   mem_load_en,
    input  logic [2:0]             mem_funct3,
    input  logic [DATA_WIDTH-1:0]  mem_load_data,
    input  logic                   wb_stall,
    input  logic                   wb_flush,
    output logic [RADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]  wdata,
    output logic                   wen,
    output logic                   wb_valid,
    output logic                   load_err,
    output logic [63:0]            instret
);

    // funct3 codes 011, 110 and 111 are not defined for loads
    function automatic logic is_reserved(input logic [2:0] f3);
        logic r;
        case (f3)
            3'b011, 3'b110, 3'b111: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Little-endian byte/halfword selection with sign or zero extension
    function automatic logic [DATA_WIDTH-1:0] extract_load(
        input logic [2:0]            f3,
        input logic [1:0]            off,
        input logic [DATA_WIDTH-1:0] word
    );
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        // Halfword select uses off[1] only; misaligned low bit is ignored
        if (off[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (f3)
            3'b000:  r = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b001:  r = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, h};
            default: r = {DATA_WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    logic                   accept_s;
    logic                   valid_d,     valid_q;
    logic [RADDR_WIDTH-1:0] rd_d,        rd_q;
    logic                   rd_wen_d,    rd_wen_q;
    logic [DATA_WIDTH-1:0]  alu_d,       alu_q;
    logic                   load_en_d,   load_en_q;
    logic [2:0]             funct3_d,    funct3_q;
    logic [DATA_WIDTH-1:0]  load_data_d, load_data_q;
    logic                   reserved_s;

    // Handshake: flush kills the incoming entry even when ready
    always_comb begin
        mem_ready = ~wb_stall;
        accept_s  = mem_valid & ~wb_stall & ~wb_flush;
    end

    // Payload next-state: load on accept, otherwise hold
    always_comb begin
        valid_d     = accept_s;
        rd_d        = rd_q;
        rd_wen_d    = rd_wen_q;
        alu_d       = alu_q;
        load_en_d   = load_en_q;
        funct3_d    = funct3_q;
        load_data_d = load_data_q;
        if (accept_s) begin
            rd_d        = mem_rd_addr;
            rd_wen_d    = mem_rd_wen;
            alu_d       = mem_alu_result;
            load_en_d   = mem_load_en;
            funct3_d    = mem_funct3;
            load_data_d = mem_load_data;
        end else begin
            rd_d        = rd_q;
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rd_q        <= {RADDR_WIDTH{1'b0}};
            rd_wen_q    <= 1'b0;
            alu_q       <= {DATA_WIDTH{1'b0}};
            load_en_q   <= 1'b0;
            funct3_q    <= 3'b000;
            load_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            rd_wen_q    <= rd_wen_d;
            alu_q       <= alu_d;
            load_en_q   <= load_en_d;
            funct3_q    <= funct3_d;
            load_data_q <= load_data_d;
        end
    end

    // Regfile write port derived from the registered payload
    always_comb begin
        reserved_s = load_en_q & is_reserved(funct3_q);
        if (load_en_q) begin
            wdata = extract_load(funct3_q, alu_q[1:0], load_data_q);
        end else begin
            wdata = alu_q;
        end
        wb_valid = valid_q;
        waddr    = rd_q;
        load_err = valid_q & reserved_s;
        wen      = valid_q & rd_wen_q & (rd_q != {RADDR_WIDTH{1'b0}}) & ~reserved_s;
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_d, instret_q;

    // Count every retiring entry, including x0 writes and load errors
    always_comb begin
        if (valid_q) begin
            instret_d = instret_q + 64'd1;
        end else begin
            instret_d = instret_q;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^64
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= 64'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage : directed-vector bench for wb_stage with hand-computed
// expected values. Works with WB_INSTRET_EN defined or undefined.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_wen;
    logic [31:0] mem_alu_result;
    logic        mem_load_en;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_load_data;
    logic        wb_stall;
    logic        wb_flush;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    logic        wb_valid;
    logic        load_err;
    logic [63:0] instret;

    int vec_cnt;
    int err_cnt;
    int retired_exp;   // expected count of retirements
    bit pending_v;     // an entry is expected to be held in the stage

    wb_stage #(.DATA_WIDTH(32), .RADDR_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd_addr(mem_rd_addr), .mem_rd_wen(mem_rd_wen),
        .mem_alu_result(mem_alu_result), .mem_load_en(mem_load_en),
        .mem_funct3(mem_funct3), .mem_load_data(mem_load_data),
        .wb_stall(wb_stall), .wb_flush(wb_flush),
        .waddr(waddr), .wdata(wdata), .wen(wen), .wb_valid(wb_valid),
        .load_err(load_err), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_instret();
`ifdef WB_INSTRET_EN
        return 64'(retired_exp);
`else
        return 64'd0;
`endif
    endfunction

    // One clock edge; acc says whether an accept is expected at this edge
    task automatic tick(input bit acc);
        @(posedge clk);
        if (pending_v) retired_exp++;
        pending_v = acc;
        #1;
    endtask

    task automatic send(input logic [4:0] rd, input logic rdw, input logic [31:0] alu,
                        input logic ld, input logic [2:0] f3, input logic [31:0] ldata);
        mem_valid      = 1'b1;
        mem_rd_addr    = rd;
        mem_rd_wen     = rdw;
        mem_alu_result = alu;
        mem_load_en    = ld;
        mem_funct3     = f3;
        mem_load_data  = ldata;
        tick(1'b1);
        mem_valid      = 1'b0;
    endtask

    task automatic do_reset();
        mem_valid = 1'b0;
        rst_n     = 1'b0;
        retired_exp = 0;
        pending_v   = 1'b0;
        #12;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [31:0] ld_alu [8];
    logic [2:0]  ld_f3  [8];
    logic [31:0] ld_exp [8];

    initial begin
        vec_cnt = 0; err_cnt = 0; retired_exp = 0; pending_v = 1'b0;
        rst_n = 1'b0; mem_valid = 1'b0; mem_rd_addr = 5'd0; mem_rd_wen = 1'b0;
        mem_alu_result = 32'd0; mem_load_en = 1'b0; mem_funct3 = 3'd0;
        mem_load_data = 32'd0; wb_stall = 1'b0; wb_flush = 1'b0;
        #3;
        check_eq("rst_wen",      {63'd0, wen},      64'd0);
        check_eq("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check_eq("rst_load_err", {63'd0, load_err}, 64'd0);
        check_eq("rst_waddr",    {59'd0, waddr},    64'd0);
        check_eq("rst_wdata",    {32'd0, wdata},    64'd0);
        check_eq("rst_instret",  instret,           64'd0);
        do_reset();

        // Basic write
        send(5'd5, 1'b1, 32'h1234_5678, 1'b0, 3'b000, 32'd0);
        check_eq("basic_wen",      {63'd0, wen},      64'd1);
        check_eq("basic_waddr",    {59'd0, waddr},    64'd5);
        check_eq("basic_wdata",    {32'd0, wdata},    64'h1234_5678);
        check_eq("basic_wb_valid", {63'd0, wb_valid}, 64'd1);
        tick(1'b0);
        check_eq("basic_wen_off",  {63'd0, wen},      64'd0);
        check_eq("basic_instret",  instret,           exp_instret());

        // Load extraction, word 0x80FF7F01: bytes 01,7F,FF,80
        ld_alu[0] = 32'h100; ld_f3[0] = 3'b000; ld_exp[0] = 32'h0000_0001;
        ld_alu[1] = 32'h101; ld_f3[1] = 3'b000; ld_exp[1] = 32'h0000_007F;
        ld_alu[2] = 32'h102; ld_f3[2] = 3'b000; ld_exp[2] = 32'hFFFF_FFFF;
        ld_alu[3] = 32'h103; ld_f3[3] = 3'b000; ld_exp[3] = 32'hFFFF_FF80;
        ld_alu[4] = 32'h103; ld_f3[4] = 3'b100; ld_exp[4] = 32'h0000_0080;
        ld_alu[5] = 32'h102; ld_f3[5] = 3'b001; ld_exp[5] = 32'hFFFF_80FF;
        ld_alu[6] = 32'h100; ld_f3[6] = 3'b101; ld_exp[6] = 32'h0000_7F01;
        ld_alu[7] = 32'h101; ld_f3[7] = 3'b010; ld_exp[7] = 32'h80FF_7F01;
        for (int i = 0; i < 8; i++) begin
            send(5'd3, 1'b1, ld_alu[i], 1'b1, ld_f3[i], 32'h80FF_7F01);
            check_eq($sformatf("load%0d_wdata", i), {32'd0, wdata}, {32'd0, ld_exp[i]});
            check_eq($sformatf("load%0d_wen", i),   {63'd0, wen},   64'd1);
        end
        tick(1'b0);
        check_eq("load_instret", instret, exp_instret());

        // Write to x0 retires but does not write
        send(5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3'b000, 32'd0);
        check_eq("x0_wen",      {63'd0, wen},      64'd0);
        check_eq("x0_wb_valid", {63'd0, wb_valid}, 64'd1);
        tick(1'b0);
        check_eq("x0_instret",  instret, exp_instret());

        // Reserved load codes
        send(5'd7, 1'b1, 32'h100, 1'b1, 3'b011, 32'h80FF_7F01);
        check_eq("rsv011_err",   {63'd0, load_err}, 64'd1);
        check_eq("rsv011_wen",   {63'd0, wen},      64'd0);
        check_eq("rsv011_wdata", {32'd0, wdata},    64'd0);
        send(5'd7, 1'b1, 32'h100, 1'b1, 3'b110, 32'h80FF_7F01);
        check_eq("rsv110_err",   {63'd0, load_err}, 64'd1);
        check_eq("rsv110_wen",   {63'd0, wen},      64'd0);
        tick(1'b0);
        check_eq("rsv_err_clr",  {63'd0, load_err}, 64'd0);
        check_eq("rsv_instret",  instret, exp_instret());

        // Stall, flush, and both
        mem_valid = 1'b1; mem_rd_addr = 5'd9; mem_rd_wen = 1'b1; mem_load_en = 1'b0;
        mem_alu_result = 32'hAAAA_5555;
        check_eq("ready_idle", {63'd0, mem_ready}, 64'd1);
        wb_stall = 1'b1;
        #1;
        check_eq("stall_ready", {63'd0, mem_ready}, 64'd0);
        tick(1'b0);
        check_eq("stall_valid", {63'd0, wb_valid}, 64'd0);
        wb_stall = 1'b0; wb_flush = 1'b1;
        tick(1'b0);
        check_eq("flush_wen",   {63'd0, wen},      64'd0);
        check_eq("flush_valid", {63'd0, wb_valid}, 64'd0);
        wb_stall = 1'b1;
        tick(1'b0);
        check_eq("both_wen",    {63'd0, wen},      64'd0);
        check_eq("both_valid",  {63'd0, wb_valid}, 64'd0);
        wb_stall = 1'b0; wb_flush = 1'b0; mem_valid = 1'b0;
        tick(1'b0);
        check_eq("sf_instret",  instret, exp_instret());

        // Back-to-back accepts after a fresh reset
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send(5'(i), 1'b1, 32'(i * 16), 1'b0, 3'b000, 32'd0);
            check_eq($sformatf("b2b%0d_wen", i),   {63'd0, wen},   64'd1);
            check_eq($sformatf("b2b%0d_waddr", i), {59'd0, waddr}, 64'(i));
            check_eq($sformatf("b2b%0d_wdata", i), {32'd0, wdata}, 64'(i * 16));
        end
        tick(1'b0);
        check_eq("b2b_instret", instret, exp_instret());
`ifdef WB_INSTRET_EN
        check_eq("b2b_instret4", instret, 64'd4);
`else
        check_eq("b2b_instret0", instret, 64'd0);
`endif

        // Async reset while an entry is held
        send(5'd11, 1'b1, 32'h0BAD_F00D, 1'b0, 3'b000, 32'd0);
        check_eq("pre_rst_wen", {63'd0, wen}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_wen",     {63'd0, wen},      64'd0);
        check_eq("arst_valid",   {63'd0, wb_valid}, 64'd0);
        check_eq("arst_instret", instret,           64'd0);
        retired_exp = 0; pending_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b0);
        check_eq("post_rst_wen",   {63'd0, wen},      64'd0);
        check_eq("post_rst_valid", {63'd0, wb_valid}, 64'd0);
        send(5'd12, 1'b1, 32'h1357_9BDF, 1'b0, 3'b000, 32'd0);
        check_eq("post_rst_new_wen",   {63'd0, wen},   64'd1);
        check_eq("post_rst_new_wdata", {32'd0, wdata}, 64'h1357_9BDF);
        tick(1'b0);
        check_eq("post_rst_instret", instret, exp_instret());

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
